dmem_responder: RTL

Data-memory responder for the multicycle CPU: the memory-side end of the load/store request interface driven by the control FSM during its memory-access state. It accepts one word read or write per four-phase req/ack handshake. Each access is delayed by a parameterised number of wait states to model slow memory. It flags misaligned byte addresses with an error response instead of performing the access.

---
 rtl/dmem_responder.sv | 106 ++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the multicycle CPU: one word read or write per
// four-phase req/ack handshake, delayed by WAIT cycles, with misalignment errors.
module dmem_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int WAIT   = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W+1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              err,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt;
  logic                we_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   mem [2**ADDR_W];

  logic                access_edge;
  logic                aligned;
  logic [ADDR_W-1:0]   word_idx;

  assign access_edge = (state == S_WAIT) && (cnt == 4'd0);
  assign aligned     = (addr_q[1:0] == 2'b00);
  assign word_idx    = addr_q[ADDR_W+1:2];

  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (req)              state_nxt = S_WAIT;
      S_WAIT:  if (cnt == 4'd0)      state_nxt = S_RESP;
      S_RESP:  if (!req)             state_nxt = S_IDLE;
      default:                       state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      ack     <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt     <= 4'(WAIT);
            busy    <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            ack <= 1'b1;
            if (!aligned) begin
              err   <= 1'b1;
              rdata <= '0;
            end else begin
              err <= 1'b0;
              if (!we_q) rdata <= mem[word_idx];
            end
          end
        end
        S_RESP: begin
          if (!req) begin
            ack  <= 1'b0;
            err  <= 1'b0;
            busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the array has no reset; contents survive reset_n and start undefined.
  // A reset before the access edge returns state to IDLE, so the write is dropped.
  always_ff @(posedge clock) begin
    if (access_edge && aligned && we_q) mem[word_idx] <= wdata_q;
  end

endmodule
